macguffin_sbox_bank: RTL and testbench
======================================

# macguffin_sbox_bank

- Parametrised, run-time programmable bank of NUM_SBOX lookup S-boxes, each mapping IN_W bits to OUT_W bits.
- Defaults reproduce the MacGuffin round function's eight 6→2 S-boxes.
- Adds a registered valid/ready lookup pipeline, a table-programming port and a restore-to-default command.
- Sits between the MacGuffin round-key XOR and the right-half update in the round datapath; also lets the team evaluate alternative S-box sets without resynthesis.

## Interface

- NUM_SBOX, 8, number of parallel S-boxes (1..16)
- IN_W, 6, input index width per S-box
- OUT_W, 2, output width per S-box
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- s_valid  input  1  lookup request valid
- s_ready  output  1  bank can accept a lookup
- s_data  input  NUM_SBOX*IN_W  index for box k at [k*IN_W +: IN_W]
- m_valid  output  1  result valid
- m_ready  input  1  downstream accepts result
- m_data  output  NUM_SBOX*OUT_W  result of box k at [k*OUT_W +: OUT_W]
- cfg_we  input  1  write one table entry
- cfg_sel  input  max(1,$clog2(NUM_SBOX))  target box
- cfg_addr  input  IN_W  target entry
- cfg_data  input  OUT_W  entry value
- cfg_restore  input  1  reload all tables with defaults

## Operation

- Tables are register arrays of NUM_SBOX × 2^IN_W × OUT_W bits.
- Default contents:
  - When IN_W==6 and OUT_W==2, box k defaults to MACGUFFIN_SBOX[k mod 8].
  - Otherwise every entry defaults to 0.
- On rst, and on any cycle with cfg_restore=1, all tables load their defaults.
- cfg_restore has priority over cfg_we in the same cycle; the write is dropped.
- cfg_we with cfg_sel ≥ NUM_SBOX is ignored, and sticky status cfg_err (internal, exported for debug) is set; rst clears it.
- Lookup handshake:
  - A lookup is accepted when s_valid && s_ready.
  - m_data is registered from the tables as they stand before that edge's config update.
  - A write or restore in the same cycle as acceptance affects only later lookups.
- Output register holds its value while m_valid && !m_ready; m_data is stable until the transfer.
- s_ready = !m_valid || m_ready: full throughput, no bubble.
- Table writes never disturb a result already held in the output register.
- Reset mid-operation: the held result is discarded.

## Timing

- Reset values:
  - m_valid=0, m_data=0, s_ready=1 (combinational from m_valid), cfg_err=0.
  - Tables hold their defaults.
- Latency: 1 cycle from accept to m_valid=1.
- Throughput: 1 lookup/cycle while m_ready=1.
- Back-pressure: with m_valid=1 and m_ready=0, s_ready=0; s_data is ignored until s_ready rises.
- Config write latency: 1 cycle. A write at edge N is visible to a lookup accepted at edge N+1.
- Restore latency: 1 cycle, all entries simultaneously.
- Simultaneous write and lookup of the same entry: the lookup returns the old value.
- No combinational path from s_data or cfg_* to m_data.

## Structure

- Package macguffin_pkg holds:
  - constant MACGUFFIN_SBOX[0:7][0:63] of 2-bit entries;
  - box 0 is S1 = {2,0,0,3,3,1,1,0, 0,2,3,0,3,3,2,1, 1,2,2,0,0,2,2,3, 1,3,3,1,0,1,1,2, 0,3,1,2,2,2,2,0, 3,0,0,3,0,1,3,1, 3,1,2,3,3,1,1,2, 1,2,2,0,1,0,0,3} (index 0 first);
  - localparams for the default widths.
- One sub-module: sbox_table, a single IN_W→OUT_W programmable table with write port, restore and combinational read.
- The bank instantiates NUM_SBOX copies and owns the handshake register.

## Test plan

- Reset, then accept s_data with box0 index 0, then 63 → m_data[1:0]=2, then 3; m_valid rises 1 cycle after each accept.
- Stream indices 0..63 to box0 with m_ready=1 → 64 consecutive results match S1, no bubbles, s_ready stays 1.
- Write box0 entry 15 := 3, accepting box0 index 15 in the same cycle → first result 1, lookup next cycle returns 3. Then pulse cfg_restore → lookup returns 1 again.
- Hold m_ready=0 for 5 cycles after one accept → m_data constant, s_ready=0, new s_valid ignored. Release → single transfer, then next accept.
- Assert cfg_we with cfg_sel=NUM_SBOX (parameter NUM_SBOX=5) → no table changes, cfg_err=1 until rst.
- Assert rst while m_valid=1 and m_ready=0 → m_valid=0 immediately; box0 entry 15 reads 1 after release.

Source files
------------

// File: rtl/macguffin_pkg.sv
// Shared constants for the MacGuffin S-box bank: default widths and the eight
// 6->2 MacGuffin S-boxes, built from the DES S-box rows by keeping the two outer output bits.
package macguffin_pkg;

  localparam int DEF_NUM_SBOX = 8;
  localparam int DEF_IN_W     = 6;
  localparam int DEF_OUT_W    = 2;

  typedef logic [0:7][0:63][1:0] mg_sbox_t;
  typedef logic [0:7][0:3][63:0] des_rows_t;

  // DES S1..S8, four rows each, column 0 in the most significant nibble.
  localparam des_rows_t DES_ROWS = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // Raw 6-bit index: row = {b5,b0}, column = b4..b1; result = {nibble bit 3, nibble bit 0}.
  function automatic mg_sbox_t gen_macguffin_sbox();
    mg_sbox_t   t;
    logic [5:0] idx;
    logic [1:0] row;
    logic [3:0] col;
    logic [3:0] nib;
    t = '0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 64; i++) begin
        idx      = 6'(i);
        row      = {idx[5], idx[0]};
        col      = idx[4:1];
        nib      = DES_ROWS[k][row][4 * (15 - int'(col)) +: 4];
        t[k][i]  = {nib[3], nib[0]};
      end
    end
    return t;
  endfunction

  localparam mg_sbox_t MACGUFFIN_SBOX = gen_macguffin_sbox();

endpackage

// File: rtl/sbox_table.sv
// One programmable IN_W->OUT_W lookup table: register array with a single write
// port, whole-table restore to defaults, and a combinational read.
module sbox_table
  import macguffin_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int BOX_IDX = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restore_i,
  input  logic             we_i,
  input  logic [IN_W-1:0]  waddr_i,
  input  logic [OUT_W-1:0] wdata_i,
  input  logic [IN_W-1:0]  raddr_i,
  output logic [OUT_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** IN_W;

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [OUT_W-1:0] mem_d [DEPTH];

  function automatic logic [OUT_W-1:0] default_entry(input int addr);
    logic [5:0]       a6;
    logic [2:0]       b3;
    logic [OUT_W-1:0] v;
    a6 = 6'(addr);
    b3 = 3'(BOX_IDX % 8);
    if (IN_W == 6 && OUT_W == 2) begin
      v = OUT_W'(MACGUFFIN_SBOX[b3][a6]);
    end else begin
      v = '0;
    end
    return v;
  endfunction

  // Restore wins over a same-cycle write.
  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      mem_d[a] = mem_q[a];
    end
    if (restore_i) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_d[a] = default_entry(a);
      end
    end else if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end else begin
      mem_d[0] = mem_q[0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= default_entry(a);
      end
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= mem_d[a];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/macguffin_sbox_bank.sv
// Bank of NUM_SBOX programmable S-boxes behind a registered valid/ready stage;
// results are sampled from the tables as they stood before the same edge's config update.
module macguffin_sbox_bank
  import macguffin_pkg::*;
#(
  parameter int NUM_SBOX = DEF_NUM_SBOX,
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  input  logic [NUM_SBOX*IN_W-1:0]                      s_data,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic [NUM_SBOX*OUT_W-1:0]                     m_data,
  input  logic                                          cfg_we,
  input  logic [((NUM_SBOX > 1) ? $clog2(NUM_SBOX) : 1)-1:0] cfg_sel,
  input  logic [IN_W-1:0]                               cfg_addr,
  input  logic [OUT_W-1:0]                              cfg_data,
  input  logic                                          cfg_restore,
  output logic                                          cfg_err
);

  localparam int SEL_W = (NUM_SBOX > 1) ? $clog2(NUM_SBOX) : 1;

  logic                        m_valid_q, m_valid_d;
  logic [NUM_SBOX*OUT_W-1:0]   m_data_q, m_data_d;
  logic [NUM_SBOX*OUT_W-1:0]   lookup_s;
  logic                        cfg_err_q, cfg_err_d;
  logic                        accept_s;
  logic                        sel_ok_s;

  assign s_ready  = !m_valid_q || m_ready;
  assign accept_s = s_valid && s_ready;
  assign sel_ok_s = (int'(cfg_sel) < NUM_SBOX);

  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_box
    logic we_s;
    assign we_s = cfg_we && (cfg_sel == SEL_W'(k));

    sbox_table #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .BOX_IDX (k)
    ) u_table (
      .clk_i     (clk),
      .rst_i     (rst),
      .restore_i (cfg_restore),
      .we_i      (we_s),
      .waddr_i   (cfg_addr),
      .wdata_i   (cfg_data),
      .raddr_i   (s_data[k*IN_W +: IN_W]),
      .rdata_o   (lookup_s[k*OUT_W +: OUT_W])
    );
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    cfg_err_d = cfg_err_q | (cfg_we && !sel_ok_s);
    if (accept_s) begin
      m_valid_d = 1'b1;
      m_data_d  = lookup_s;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_macguffin_sbox_bank.sv
// Randomized self-checking bench: a queue/array reference model of the bank for the
// default 8-box instance plus directed checks of a 5-box instance for bad selects.
module tb_macguffin_sbox_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [47:0] s_data;
  logic [15:0] m_data;
  logic        cfg_we, cfg_restore, cfg_err;
  logic [2:0]  cfg_sel;
  logic [5:0]  cfg_addr;
  logic [1:0]  cfg_data;

  logic        d5_s_valid, d5_s_ready, d5_m_valid, d5_m_ready;
  logic [29:0] d5_s_data;
  logic [9:0]  d5_m_data;
  logic        d5_cfg_we, d5_cfg_restore, d5_cfg_err;
  logic [2:0]  d5_cfg_sel;
  logic [5:0]  d5_cfg_addr;
  logic [1:0]  d5_cfg_data;

  macguffin_sbox_bank dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_restore(cfg_restore), .cfg_err(cfg_err)
  );

  macguffin_sbox_bank #(.NUM_SBOX(5)) dut5 (
    .clk(clk), .rst(rst), .s_valid(d5_s_valid), .s_ready(d5_s_ready), .s_data(d5_s_data),
    .m_valid(d5_m_valid), .m_ready(d5_m_ready), .m_data(d5_m_data), .cfg_we(d5_cfg_we),
    .cfg_sel(d5_cfg_sel), .cfg_addr(d5_cfg_addr), .cfg_data(d5_cfg_data),
    .cfg_restore(d5_cfg_restore), .cfg_err(d5_cfg_err)
  );

  int unsigned s1_tab [64] = '{2,0,0,3,3,1,1,0, 0,2,3,0,3,3,2,1, 1,2,2,0,0,2,2,3, 1,3,3,1,0,1,1,2,
                               0,3,1,2,2,2,2,0, 3,0,0,3,0,1,3,1, 3,1,2,3,3,1,1,2, 1,2,2,0,1,0,0,3};

  // Reference model: table contents, which entries the bench knows, and pending results.
  logic [1:0] tbl   [8][64];
  bit         known [8][64];
  typedef struct { logic [15:0] data; logic [15:0] mask; } res_t;
  res_t exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_restore();
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 64; i++) begin
        if (k == 0) begin
          tbl[0][i]   = 2'(s1_tab[i]);
          known[0][i] = 1'b1;
        end else begin
          known[k][i] = 1'b0;
        end
      end
    end
  endfunction

  function automatic res_t model_lookup(input logic [47:0] sd);
    res_t       r;
    logic [5:0] idx;
    r.data = '0;
    r.mask = '0;
    for (int k = 0; k < 8; k++) begin
      idx = sd[k*6 +: 6];
      if (known[k][idx]) begin
        r.data[k*2 +: 2] = tbl[k][idx];
        r.mask[k*2 +: 2] = 2'b11;
      end
    end
    return r;
  endfunction

  function automatic logic [47:0] rnd48();
    return 48'({$urandom(), $urandom()});
  endfunction

  // One clock: update the model from the inputs held across the edge, then check outputs.
  task automatic tick();
    bit occ;
    @(posedge clk);
    occ = (exp_q.size() != 0);
    if (rst) begin
      exp_q.delete();
      model_restore();
    end else begin
      if (occ && m_ready) void'(exp_q.pop_front());
      if (s_valid && (!occ || m_ready)) exp_q.push_back(model_lookup(s_data));
      if (cfg_restore) begin
        model_restore();
      end else if (cfg_we) begin
        tbl[cfg_sel][cfg_addr]   = cfg_data;
        known[cfg_sel][cfg_addr] = 1'b1;
      end
    end
    @(negedge clk);
    chk("s_ready", s_ready, (exp_q.size() == 0) || m_ready);
    chk("m_valid", m_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("m_data", m_data & exp_q[0].mask, exp_q[0].data & exp_q[0].mask);
  endtask

  task automatic d5_tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; s_data = '0;
    cfg_we = 1'b0; cfg_restore = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
    d5_s_valid = 1'b0; d5_m_ready = 1'b1; d5_s_data = '0; d5_cfg_we = 1'b0;
    d5_cfg_restore = 1'b0; d5_cfg_sel = '0; d5_cfg_addr = '0; d5_cfg_data = '0;
    model_restore();

    tick();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 16'h0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_cfg_err", cfg_err, 1'b0);
    rst = 1'b0;

    s_valid = 1'b1; s_data = rnd48(); s_data[5:0] = 6'd0;
    tick();
    chk("tp_idx0", m_data[1:0], 2'd2);
    s_data = rnd48(); s_data[5:0] = 6'd63;
    tick();
    chk("tp_idx63", m_data[1:0], 2'd3);
    s_valid = 1'b0;
    tick();

    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1; s_data = rnd48(); s_data[5:0] = 6'(i);
      tick();
      chk("stream_s1", m_data[1:0], 2'(s1_tab[i]));
    end
    s_valid = 1'b0;
    tick();

    for (int k = 1; k < 8; k++) begin
      for (int i = 0; i < 64; i++) begin
        cfg_we = 1'b1; cfg_sel = 3'(k); cfg_addr = 6'(i); cfg_data = 2'($urandom_range(0, 3));
        tick();
      end
    end
    cfg_we = 1'b0;

    s_valid = 1'b1; s_data = rnd48(); s_data[5:0] = 6'd15;
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_addr = 6'd15; cfg_data = 2'd3;
    tick();
    chk("wr_same_cycle_old", m_data[1:0], 2'd1);
    cfg_we = 1'b0;
    tick();
    chk("wr_next_new", m_data[1:0], 2'd3);
    s_valid = 1'b0; cfg_restore = 1'b1;
    tick();
    cfg_restore = 1'b0; s_valid = 1'b1;
    tick();
    chk("restore_default", m_data[1:0], 2'd1);
    s_valid = 1'b0;
    tick();

    s_valid = 1'b1; s_data = rnd48(); s_data[5:0] = 6'd15;
    tick();
    m_ready = 1'b0; cfg_we = 1'b1; cfg_sel = 3'd0; cfg_addr = 6'd15; cfg_data = 2'd0;
    for (int c = 0; c < 5; c++) begin
      s_data = rnd48();
      tick();
      cfg_we = 1'b0;
      chk("bp_s_ready", s_ready, 1'b0);
      chk("bp_hold", m_data[1:0], 2'd1);
    end
    m_ready = 1'b1; s_valid = 1'b0;
    tick();
    chk("bp_release", m_valid, 1'b0);
    s_valid = 1'b1; s_data[5:0] = 6'd15;
    tick();
    chk("bp_next_accept", m_data[1:0], 2'd0);
    s_valid = 1'b0; cfg_restore = 1'b1;
    tick();
    cfg_restore = 1'b0;

    for (int c = 0; c < 2000; c++) begin
      s_valid     = ($urandom_range(0, 3) != 0);
      m_ready     = ($urandom_range(0, 3) != 0);
      s_data      = rnd48();
      cfg_we      = ($urandom_range(0, 3) == 0);
      cfg_sel     = 3'($urandom_range(0, 7));
      cfg_addr    = 6'($urandom_range(0, 63));
      cfg_data    = 2'($urandom_range(0, 3));
      cfg_restore = ($urandom_range(0, 99) == 0);
      tick();
    end

    cfg_we = 1'b0; cfg_restore = 1'b0; m_ready = 1'b1; s_valid = 1'b1; s_data = rnd48();
    tick();
    s_valid = 1'b0; m_ready = 1'b0;
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_addr = 6'd15; cfg_data = 2'd2;
    tick();
    cfg_we = 1'b0;
    chk("arst_pre_valid", m_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_s_ready", s_ready, 1'b1);
    tick();
    rst = 1'b0; m_ready = 1'b1; s_valid = 1'b1; s_data = rnd48(); s_data[5:0] = 6'd15;
    tick();
    chk("arst_table_default", m_data[1:0], 2'd1);
    s_valid = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) begin
      d5_cfg_we = 1'b1; d5_cfg_sel = 3'(k); d5_cfg_addr = 6'd15; d5_cfg_data = 2'd2;
      d5_tick();
    end
    chk("d5_err_clean", d5_cfg_err, 1'b0);
    d5_cfg_sel = 3'd5; d5_cfg_data = 2'd3;
    d5_tick();
    chk("d5_err_set", d5_cfg_err, 1'b1);
    d5_cfg_sel = 3'd7;
    d5_tick();
    d5_cfg_sel = 3'd6;
    d5_tick();
    d5_cfg_we = 1'b0; d5_s_valid = 1'b1; d5_s_data = {5{6'd15}};
    d5_tick();
    chk("d5_m_valid", d5_m_valid, 1'b1);
    chk("d5_no_change", d5_m_data, {5{2'd2}});
    d5_s_valid = 1'b0;
    repeat (3) d5_tick();
    chk("d5_err_sticky", d5_cfg_err, 1'b1);
    rst = 1'b1;
    d5_tick();
    chk("d5_err_rst", d5_cfg_err, 1'b0);
    rst = 1'b0;
    d5_tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
